divisor_algoritmico_param: RTL and testbench
============================================

Name: divisor_algoritmico_param

Overview:
Iterative radix-2 restoring divider that replaces the parallel behavioural divider model.
- Operands and width are parametrised; a per-operation mode input selects signed or unsigned division.
- Uses a Start/Done/Busy handshake and flags division by zero.
- Sits behind the same stimulus interface as the reference model, so the bench can compare Coc/Res/Done against it cycle-accurately.

Parameters:
TAMANYO, 32, operand/result width in bits (legal range 4..64)

Ports:
CLK  input  1  clock, all state updated on rising edge
RSTa  input  1  reset, asynchronous, active-low
Start  input  1  request; sampled only in IDLE
Signed  input  1  1 = two's-complement division, 0 = unsigned; sampled with Start
Num  input  TAMANYO  dividend; sampled with Start
Den  input  TAMANYO  divisor; sampled with Start
Coc  output  TAMANYO  quotient, registered, held until next Done
Res  output  TAMANYO  remainder, registered, held until next Done
Done  output  1  one-cycle pulse, Coc/Res/DivZero valid
Busy  output  1  high in LOAD..FIX, low in IDLE
DivZero  output  1  Den was 0 for the completed operation; held with Coc/Res

Behaviour:
- Reset (RSTa=0, asynchronous):
  - state=IDLE; Coc, Res, Done, Busy, DivZero, counter and all datapath registers = 0.
  - Reset mid-operation aborts the operation; no Done is produced.
- FSM states: IDLE, ITER, FIX.
  - IDLE: on edge with Start=1, capture Signed, sign_num = Signed & Num[MSB], sign_den = Signed & Den[MSB].
    - Capture |Num| and |Den| (two's-complement negate when the sign bit applies); partial remainder R=0; cnt=0 -> ITER.
    - Start=0 -> stay in IDLE.
  - ITER: one quotient bit per edge, MSB first.
    - R' = {R, Q[MSB]} (TAMANYO+1 bits); Q shifted left.
    - If R' >= D: R = R' - D and new Q LSB = 1; else R = R' and LSB = 0.
    - cnt increments; after TAMANYO iterations -> FIX.
  - FIX, normal case: Coc = Q, negated if sign_num ^ sign_den; Res = R[TAMANYO-1:0], negated if sign_num.
    - Remainder sign follows the dividend (truncating division, identical to SystemVerilog / and %).
  - FIX, division by zero (Den==0): Coc = all ones; Res = Num (original, unmodified); DivZero = 1.
  - FIX always: Done = 1 for exactly this cycle -> IDLE.
- Latency:
  - Done is set by the (TAMANYO+1)th rising edge after the edge that sampled Start.
  - Latency is fixed and independent of operand values or division by zero.
- Busy is 1 from the edge after Start capture until the edge that sets Done; Busy=0 while Done=1.
- Start handling:
  - Start while Busy=1 is ignored; not queued.
  - Start may be asserted in the cycle Done=1; it is accepted (back-to-back issue every TAMANYO+2 cycles).
- Num/Den/Signed may change freely after the capture edge without affecting the result.
- Signed overflow MIN/-1 gives Coc = MIN, Res = 0. This falls out of the unsigned magnitude path; no special case is required.
- Unsigned mode: no negation in LOAD or FIX.
- Outputs are all registered; no combinational path from inputs to outputs.

Decomposition:
- Package divisor_pkg:
  - typedef enum logic [1:0] estado_t {IDLE, ITER, FIX}.
  - Function abs_cond(value, enable) for conditional two's-complement negation, used in both capture and FIX.
  - Localparam for counter width, $clog2(TAMANYO+1).
- Sub-module divisor_paso_restaurador (parametrised by TAMANYO): purely combinational single iteration.
  - Inputs R, Q, D.
  - Outputs next R, next Q.
  - Instantiated once inside the ITER datapath.

Test Plan (TAMANYO=8 unless stated):
- Signed=1, Num=0xF9 (-7), Den=0x02, Start 1 cycle -> Done exactly 9 edges after the capture edge, Coc=0xFD (-3), Res=0xFF (-1), DivZero=0; Busy high 8 cycles.
- Signed=0, Num=0xF9 (249), Den=0x02 -> Coc=0x7C, Res=0x01; same latency.
- Num=0x25, Den=0x00, both modes -> Coc=0xFF, Res=0x25, DivZero=1, latency unchanged.
- Signed=1, Num=0x80, Den=0xFF -> Coc=0x80, Res=0x00; unsigned mode gives Coc=0x00, Res=0x80.
- Start held high continuously with changing operands -> operations issued every 10 cycles; operands changed mid-operation do not alter results.
- RSTa pulsed low at iteration 4 -> all outputs 0 immediately, no Done; next Start completes normally.
- Randomised 10^5 operations with TAMANYO=32, both modes -> match SystemVerilog $signed / and % (unsigned / and % in unsigned mode), excluding Den=0.

Source files
------------

// File: rtl/divisor_pkg.sv
// Shared types and helpers for the iterative restoring divider.
package divisor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } estado_t;

  // Widest operand the divider supports; helpers work at this width and
  // callers truncate to their own TAMANYO.
  localparam int TAMANYO_MAX = 64;

  // Iteration counter width: enough to count TAMANYO iterations.
  function automatic int ancho_cnt(input int tamanyo);
    return $clog2(tamanyo + 1);
  endfunction

  // Conditional two's-complement negation. The low bits of a negation depend
  // only on the low bits of the operand, so zero-extended inputs are fine.
  function automatic logic [TAMANYO_MAX-1:0] abs_cond(
    input logic [TAMANYO_MAX-1:0] value,
    input logic                   enable
  );
    return enable ? (~value + TAMANYO_MAX'(1)) : value;
  endfunction

endpackage

// File: rtl/divisor_paso_restaurador.sv
// One radix-2 restoring step: shift a quotient bit into the partial
// remainder, subtract the divisor when it fits, and record the quotient bit.
module divisor_paso_restaurador #(
  parameter int TAMANYO = 32
) (
  input  logic [TAMANYO-1:0] r_i,
  input  logic [TAMANYO-1:0] q_i,
  input  logic [TAMANYO-1:0] d_i,
  output logic [TAMANYO-1:0] r_o,
  output logic [TAMANYO-1:0] q_o
);

  logic [TAMANYO:0] r_ext;
  logic [TAMANYO:0] r_dif;

  // Trial subtraction on the widened remainder; restore when it would go negative.
  always_comb begin
    r_ext = {r_i, q_i[TAMANYO-1]};
    r_dif = r_ext - {1'b0, d_i};
    if (r_ext >= {1'b0, d_i}) begin
      r_o = r_dif[TAMANYO-1:0];
      q_o = {q_i[TAMANYO-2:0], 1'b1};
    end else begin
      r_o = r_ext[TAMANYO-1:0];
      q_o = {q_i[TAMANYO-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/divisor_algoritmico_param.sv
// Iterative signed/unsigned restoring divider with Start/Done/Busy handshake.
// Works on magnitudes and fixes signs at the end (truncating division).
module divisor_algoritmico_param
  import divisor_pkg::*;
#(
  parameter int TAMANYO = 32
) (
  input  logic               CLK,
  input  logic               RSTa,
  input  logic               Start,
  input  logic               Signed,
  input  logic [TAMANYO-1:0] Num,
  input  logic [TAMANYO-1:0] Den,
  output logic [TAMANYO-1:0] Coc,
  output logic [TAMANYO-1:0] Res,
  output logic               Done,
  output logic               Busy,
  output logic               DivZero
);

  localparam int CNT_W = ancho_cnt(TAMANYO);
  localparam logic [CNT_W-1:0] CNT_ULT = CNT_W'(TAMANYO - 1);

  estado_t            state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TAMANYO-1:0] r_q, r_d;
  logic [TAMANYO-1:0] q_q, q_d;
  logic [TAMANYO-1:0] d_q, d_d;
  logic [TAMANYO-1:0] num_q, num_d;
  logic               sign_num_q, sign_num_d;
  logic               sign_den_q, sign_den_d;
  logic               den_zero_q, den_zero_d;
  logic [TAMANYO-1:0] coc_q, coc_d;
  logic [TAMANYO-1:0] res_q, res_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               divzero_q, divzero_d;

  logic [TAMANYO-1:0] r_paso, q_paso;
  logic [TAMANYO-1:0] num_abs, den_abs, coc_fix, res_fix;

  divisor_paso_restaurador #(.TAMANYO(TAMANYO)) u_paso (
    .r_i (r_q),
    .q_i (q_q),
    .d_i (d_q),
    .r_o (r_paso),
    .q_o (q_paso)
  );

  // Magnitudes at capture time and sign correction of the final result.
  always_comb begin
    num_abs = TAMANYO'(abs_cond(TAMANYO_MAX'(Num), Signed & Num[TAMANYO-1]));
    den_abs = TAMANYO'(abs_cond(TAMANYO_MAX'(Den), Signed & Den[TAMANYO-1]));
    coc_fix = TAMANYO'(abs_cond(TAMANYO_MAX'(q_q), sign_num_q ^ sign_den_q));
    res_fix = TAMANYO'(abs_cond(TAMANYO_MAX'(r_q), sign_num_q));
  end

  // Next-state and datapath update for IDLE -> ITER x TAMANYO -> FIX.
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves one
    // unassigned; that is what keeps this block from inferring latches.
    state_d    = state_q;
    cnt_d      = cnt_q;
    r_d        = r_q;
    q_d        = q_q;
    d_d        = d_q;
    num_d      = num_q;
    sign_num_d = sign_num_q;
    sign_den_d = sign_den_q;
    den_zero_d = den_zero_q;
    coc_d      = coc_q;
    res_d      = res_q;
    divzero_d  = divzero_q;
    done_d     = 1'b0;
    busy_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (Start) begin
          sign_num_d = Signed & Num[TAMANYO-1];
          sign_den_d = Signed & Den[TAMANYO-1];
          q_d        = num_abs;
          d_d        = den_abs;
          num_d      = Num;
          den_zero_d = (Den == '0);
          r_d        = '0;
          cnt_d      = '0;
          state_d    = ITER;
        end
      end
      ITER: begin
        busy_d = 1'b1;
        r_d    = r_paso;
        q_d    = q_paso;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_ULT) begin
          state_d = FIX;
        end
      end
      FIX: begin
        done_d    = 1'b1;
        divzero_d = den_zero_q;
        coc_d     = den_zero_q ? '1 : coc_fix;
        res_d     = den_zero_q ? num_q : res_fix;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RSTa) begin
    // NOTE: the datapath registers are reset too, not only the control state,
    // so an aborted operation leaves nothing behind in Coc/Res.
    if (!RSTa) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      r_q        <= '0;
      q_q        <= '0;
      d_q        <= '0;
      num_q      <= '0;
      sign_num_q <= 1'b0;
      sign_den_q <= 1'b0;
      den_zero_q <= 1'b0;
      coc_q      <= '0;
      res_q      <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      divzero_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, whatever the statement order.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      r_q        <= r_d;
      q_q        <= q_d;
      d_q        <= d_d;
      num_q      <= num_d;
      sign_num_q <= sign_num_d;
      sign_den_q <= sign_den_d;
      den_zero_q <= den_zero_d;
      coc_q      <= coc_d;
      res_q      <= res_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      divzero_q  <= divzero_d;
    end
  end

  assign Coc     = coc_q;
  assign Res     = res_q;
  assign Done    = done_q;
  assign Busy    = busy_q;
  assign DivZero = divzero_q;

endmodule

// File: tb/tb_divisor_algoritmico_param.sv
// Self-checking bench for divisor_algoritmico_param: directed corner cases,
// held-Start issue cadence, mid-operation reset and randomized operations
// against an arithmetic reference model.
module tb_divisor_algoritmico_param;

  localparam int W = 8;

  logic         CLK;
  logic         RSTa;
  logic         Start;
  logic         Signed;
  logic [W-1:0] Num;
  logic [W-1:0] Den;
  logic [W-1:0] Coc;
  logic [W-1:0] Res;
  logic         Done;
  logic         Busy;
  logic         DivZero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] coc;
    logic [W-1:0] res;
    logic         dz;
  } ref_t;

  divisor_algoritmico_param #(.TAMANYO(W)) dut (
    .CLK     (CLK),
    .RSTa    (RSTa),
    .Start   (Start),
    .Signed  (Signed),
    .Num     (Num),
    .Den     (Den),
    .Coc     (Coc),
    .Res     (Res),
    .Done    (Done),
    .Busy    (Busy),
    .DivZero (DivZero)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain truncating integer division on wide signed integers.
  function automatic ref_t ref_div(input logic sgn, input logic [W-1:0] n, input logic [W-1:0] d);
    ref_t   r;
    longint nn, dd, qq, rr;
    if (d == '0) begin
      r.coc = '1;
      r.res = n;
      r.dz  = 1'b1;
    end else begin
      nn    = sgn ? longint'($signed(n)) : longint'(n);
      dd    = sgn ? longint'($signed(d)) : longint'(d);
      qq    = nn / dd;
      rr    = nn % dd;
      r.coc = qq[W-1:0];
      r.res = rr[W-1:0];
      r.dz  = 1'b0;
    end
    return r;
  endfunction

  // Issue one operation (called at posedge+1) and check latency, Busy,
  // results, the one-cycle Done pulse and that results are held.
  task automatic run_op(input string tag, input logic sgn, input logic [W-1:0] num,
                        input logic [W-1:0] den, input logic [W-1:0] exp_coc,
                        input logic [W-1:0] exp_res, input logic exp_dz);
    int lat;
    int busy_cnt;
    bit seen;
    Signed = sgn;
    Num    = num;
    Den    = den;
    Start  = 1'b1;
    @(posedge CLK); #1;
    Start  = 1'b0;
    Num    = W'($urandom);
    Den    = W'($urandom);
    Signed = 1'($urandom);
    lat      = 0;
    busy_cnt = 0;
    seen     = 1'b0;
    while (!seen && lat < 4 * W) begin
      @(posedge CLK); #1;
      lat++;
      if (Busy) busy_cnt++;
      if (Done) seen = 1'b1;
    end
    check({tag, " latency"}, lat, W + 1);
    check({tag, " busy_cycles"}, busy_cnt, W);
    check({tag, " busy_at_done"}, Busy, 1'b0);
    check({tag, " coc"}, Coc, exp_coc);
    check({tag, " res"}, Res, exp_res);
    check({tag, " divzero"}, DivZero, exp_dz);
    @(posedge CLK); #1;
    check({tag, " done_pulse"}, Done, 1'b0);
    check({tag, " coc_held"}, Coc, exp_coc);
  endtask

  initial begin
    ref_t         m;
    ref_t         expq[$];
    logic         sgn;
    logic [W-1:0] num, den;
    int           dones;

    RSTa   = 1'b0;
    Start  = 1'b0;
    Signed = 1'b0;
    Num    = '0;
    Den    = '0;
    #1;
    check("reset coc", Coc, '0);
    check("reset res", Res, '0);
    check("reset done", Done, 1'b0);
    check("reset busy", Busy, 1'b0);
    check("reset divzero", DivZero, 1'b0);
    #22 RSTa = 1'b1;
    @(posedge CLK); #1;

    // Directed corner cases with hand-derived expectations.
    run_op("s_m7_d2",   1'b1, 8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0);
    run_op("u_249_d2",  1'b0, 8'hF9, 8'h02, 8'h7C, 8'h01, 1'b0);
    run_op("u_dz",      1'b0, 8'h25, 8'h00, 8'hFF, 8'h25, 1'b1);
    run_op("s_dz",      1'b1, 8'h25, 8'h00, 8'hFF, 8'h25, 1'b1);
    run_op("s_min_m1",  1'b1, 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0);
    run_op("u_80_ff",   1'b0, 8'h80, 8'hFF, 8'h00, 8'h80, 1'b0);
    run_op("s_p7_m2",   1'b1, 8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0);

    // Start held high: a capture every W+2 edges, operands changing each cycle.
    Start = 1'b1;
    for (int k = 0; k < 5 * (W + 2); k++) begin
      Signed = 1'($urandom);
      Num    = W'($urandom);
      Den    = W'($urandom_range(1, 255));
      if (k % (W + 2) == 0) expq.push_back(ref_div(Signed, Num, Den));
      @(posedge CLK); #1;
      check($sformatf("held done k%0d", k), Done, (k % (W + 2)) == (W + 1));
      if (Done && expq.size() > 0) begin
        m = expq.pop_front();
        check($sformatf("held coc k%0d", k), Coc, m.coc);
        check($sformatf("held res k%0d", k), Res, m.res);
      end
    end
    Start = 1'b0;
    @(posedge CLK); #1;

    // Reset during the 4th iteration aborts the operation.
    Signed = 1'b0;
    Num    = 8'hC8;
    Den    = 8'h07;
    Start  = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    repeat (4) @(posedge CLK);
    #2 RSTa = 1'b0;
    #1;
    check("midrst coc", Coc, '0);
    check("midrst res", Res, '0);
    check("midrst done", Done, 1'b0);
    check("midrst busy", Busy, 1'b0);
    check("midrst divzero", DivZero, 1'b0);
    #2 RSTa = 1'b1;
    dones = 0;
    repeat (2 * W) begin
      @(posedge CLK); #1;
      if (Done) dones++;
    end
    check("midrst no_done", dones, 0);
    run_op("after_rst", 1'b0, 8'hC8, 8'h07, 8'h1C, 8'h04, 1'b0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 1500; i++) begin
      sgn = 1'($urandom);
      num = W'($urandom);
      den = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom);
      m   = ref_div(sgn, num, den);
      run_op($sformatf("rnd%0d", i), sgn, num, den, m.coc, m.res, m.dz);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
